mem_access_unit: RTL

- Memory-access stage directly upstream of Data_Memory: takes load/store requests from the execute stage and drives the data memory port.
- Buffers stores in a small FIFO store buffer and drains them to memory when the port is free.
- Returns load data, or an address-range error, on a one-cycle response strobe.

---
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory-access stage: FIFO store buffer draining to Data_Memory, loads wait for the drain.
// Define MEM_ACCESS_FWD_EN to forward buffered store data to loads instead of waiting.
module mem_access_unit #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int DEPTH    = 8,
   parameter int SB_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              sb_empty,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data
);

   localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
   localparam int CNT_W = $clog2(SB_DEPTH + 1);
   localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(SB_DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(SB_DEPTH);

   typedef enum logic [1:0] {IDLE, LD_WAIT, LD_READ, RESP} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] sbAddr_q [SB_DEPTH];
   logic [DATA_W-1:0] sbData_q [SB_DEPTH];
   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] ldAddr_q;
   logic [DATA_W-1:0] rspData_q;
   logic              rspErr_q;

   logic accept, addrOk, push, pop;

   assign req_ready = (state_q == IDLE) && (count_q != FULL_CNT);
   assign accept    = req_valid && req_ready;
   assign addrOk    = req_addr < DEPTH_A;
   assign push      = accept && req_we && addrOk;
   // The memory port is idle while reset is asserted, so a pending store is never written.
   assign pop       = (count_q != '0) && (state_q != LD_READ) && !rst;
   assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

`ifdef MEM_ACCESS_FWD_EN
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic              fwdHit;
   logic [DATA_W-1:0] fwdData;
   logic [PTR_W-1:0]  fwdIdx;

   // Walk oldest to youngest so the youngest matching store wins.
   always_comb begin
      fwdHit  = 1'b0;
      fwdData = '0;
      fwdIdx  = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         fwdIdx = PTR_W'((int'(head_q) + i) % SB_DEPTH);
         if ((i < int'(count_q)) &&
             (sbAddr_q[fwdIdx][IDX_W-1:0] == req_addr[IDX_W-1:0])) begin
            fwdHit  = 1'b1;
            fwdData = sbData_q[fwdIdx];
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         ldAddr_q  <= '0;
         rspData_q <= '0;
         rspErr_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         if (push) begin
            sbAddr_q[tail_q] <= req_addr;
            sbData_q[tail_q] <= req_wdata;
            tail_q           <= (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
         end
         if (pop) begin
            head_q <= (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (accept && !addrOk) begin
                  rspData_q <= '0;
                  rspErr_q  <= 1'b1;
                  state_q   <= RESP;
               end else if (accept && !req_we) begin
                  ldAddr_q <= req_addr;
                  rspErr_q <= 1'b0;
`ifdef MEM_ACCESS_FWD_EN
                  if (fwdHit) begin
                     rspData_q <= fwdData;
                     state_q   <= RESP;
                  end else begin
                     state_q <= LD_READ;
                  end
`else
                  state_q <= (count_d != '0) ? LD_WAIT : LD_READ;
`endif
               end
            end
            LD_WAIT: begin
               if (count_d == '0) state_q <= LD_READ;
            end
            LD_READ: begin
               rspData_q <= mem_read_data;
               rspErr_q  <= 1'b0;
               state_q   <= RESP;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rspData_q;
   assign rsp_err   = rspErr_q && (state_q == RESP);
   assign sb_empty  = (count_q == '0);

   // A load read owns the port for its single cycle; otherwise the buffer head drains.
   always_comb begin
      mem_read        = 1'b0;
      mem_write_en    = 1'b0;
      mem_access_addr = '0;
      mem_write_data  = '0;
      if (!rst) begin
         if (state_q == LD_READ) begin
            mem_read        = 1'b1;
            mem_access_addr = ldAddr_q;
         end else if (count_q != '0) begin
            mem_write_en    = 1'b1;
            mem_access_addr = sbAddr_q[head_q];
            mem_write_data  = sbData_q[head_q];
         end
      end
   end

endmodule
